// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush sequencer: state encoding, fill defaults,
// memory-port owner codes and field widths.
package pipeline_ctrl_pkg;
  localparam int unsigned STATE_W        = 2;
  localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] ST_I_FILL = 2'd1;
  localparam logic [STATE_W-1:0] ST_D_FILL = 2'd2;
  localparam logic [STATE_W-1:0] ST_HALTED = 2'd3;

  localparam int unsigned FILL_WORDS_DEF = 8;
  localparam logic        MEMSEL_I       = 1'b0;
  localparam logic        MEMSEL_D       = 1'b1;

  localparam int unsigned REG_W  = 4;
  localparam int unsigned PERF_W = 16;
endpackage

// File: rtl/pipeline_ctrl_fill_beat_counter.sv
// Fill word counter: clears at fill start, advances per returned word, wraps naturally
// (FILL_WORDS is a power of 2) and flags the last beat of a line.
module fill_beat_counter #(
  parameter int unsigned FILL_WORDS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          advance,
  output logic [$clog2(FILL_WORDS)-1:0] beat,
  output logic                          last_c
);
  localparam int unsigned BEAT_W = $clog2(FILL_WORDS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat <= '0;
    end else if (clear) begin
      beat <= '0;
    end else if (advance) begin
      beat <= beat + BEAT_W'(1);
    end
  end

  assign last_c = (beat == BEAT_W'(FILL_WORDS - 1));
endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: hazard priority, memory-port fill
// arbitration and HLT freeze. Optional perf counters under PIPE_PERF_CNT_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned FILL_WORDS = FILL_WORDS_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          icache_miss,
  input  logic                          dcache_miss,
  input  logic                          mem_valid,
  input  logic                          ex_memread,
  input  logic [REG_W-1:0]              ex_dst,
  input  logic [REG_W-1:0]              id_rs,
  input  logic [REG_W-1:0]              id_rt,
  input  logic                          id_branch_taken,
  input  logic                          wb_hlt,
  output logic                          pc_wren,
  output logic                          if_id_wren,
  output logic                          if_id_flush,
  output logic                          id_ex_wren,
  output logic                          id_ex_flush,
  output logic                          ex_mem_wren,
  output logic                          mem_wb_wren,
  output logic                          mem_req,
  output logic                          mem_sel,
  output logic [$clog2(FILL_WORDS)-1:0] fill_beat,
  output logic                          fill_done_i,
  output logic                          fill_done_d,
  output logic                          halted
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]             perf_dstall,
  output logic [PERF_W-1:0]             perf_istall,
  output logic [PERF_W-1:0]             perf_luse
`endif
);
  logic [STATE_W-1:0] state, state_nxt;
  logic mem_req_nxt, mem_sel_nxt, done_i_nxt, done_d_nxt, halted_nxt;
  logic beat_clear, beat_adv, beat_last;
  logic dmiss_ok, imiss_ok, freeze, fetch_stall, load_use;

  // A miss is masked in the cycle its own line fill reports completion.
  assign dmiss_ok = dcache_miss && !fill_done_d;
  assign imiss_ok = icache_miss && !fill_done_i;

  assign freeze      = (state == ST_D_FILL) || ((state == ST_IDLE) && dmiss_ok);
  assign fetch_stall = ((state == ST_I_FILL) || ((state == ST_IDLE) && imiss_ok)) && !freeze;
  assign load_use    = ex_memread && (ex_dst != '0) && ((ex_dst == id_rs) || (ex_dst == id_rt));

  fill_beat_counter #(.FILL_WORDS(FILL_WORDS)) u_beat (
    .clk     (clk),
    .rst     (rst),
    .clear   (beat_clear),
    .advance (beat_adv),
    .beat    (fill_beat),
    .last_c  (beat_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      mem_req     <= 1'b0;
      mem_sel     <= MEMSEL_I;
      fill_done_i <= 1'b0;
      fill_done_d <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_nxt;
      mem_req     <= mem_req_nxt;
      mem_sel     <= mem_sel_nxt;
      fill_done_i <= done_i_nxt;
      fill_done_d <= done_d_nxt;
      halted      <= halted_nxt;
    end
  end

  // Next state and registered-output values; a fill in flight is never preempted or halted.
  always_comb begin
    state_nxt   = state;
    mem_req_nxt = mem_req;
    mem_sel_nxt = mem_sel;
    done_i_nxt  = 1'b0;
    done_d_nxt  = 1'b0;
    beat_clear  = 1'b0;
    beat_adv    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wb_hlt) begin
          state_nxt = ST_HALTED;
        end else if (dmiss_ok) begin
          state_nxt   = ST_D_FILL;
          mem_req_nxt = 1'b1;
          mem_sel_nxt = MEMSEL_D;
          beat_clear  = 1'b1;
        end else if (imiss_ok) begin
          state_nxt   = ST_I_FILL;
          mem_req_nxt = 1'b1;
          mem_sel_nxt = MEMSEL_I;
          beat_clear  = 1'b1;
        end
      end
      ST_I_FILL, ST_D_FILL: begin
        if (mem_valid) begin
          beat_adv = 1'b1;
          if (beat_last) begin
            state_nxt   = ST_IDLE;
            mem_req_nxt = 1'b0;
            done_i_nxt  = (state == ST_I_FILL);
            done_d_nxt  = (state == ST_D_FILL);
          end
        end
      end
      default: state_nxt = ST_HALTED;
    endcase
    halted_nxt = (state_nxt == ST_HALTED);
  end

  // Stage enables: halt > freeze > load-use > fetch stall > branch.
  always_comb begin
    pc_wren     = 1'b1;
    if_id_wren  = 1'b1;
    if_id_flush = 1'b0;
    id_ex_wren  = 1'b1;
    id_ex_flush = 1'b0;
    ex_mem_wren = 1'b1;
    mem_wb_wren = 1'b1;
    if ((state == ST_HALTED) || freeze) begin
      pc_wren     = 1'b0;
      if_id_wren  = 1'b0;
      id_ex_wren  = 1'b0;
      ex_mem_wren = 1'b0;
      mem_wb_wren = 1'b0;
    end else if (load_use) begin
      pc_wren     = 1'b0;
      if_id_wren  = 1'b0;
      id_ex_flush = 1'b1;
    end else if (fetch_stall) begin
      pc_wren     = 1'b0;
      if_id_flush = 1'b1;
    end else if (id_branch_taken) begin
      if_id_flush = 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic count_en;
  assign count_en = (state != ST_HALTED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_dstall <= '0;
      perf_istall <= '0;
      perf_luse   <= '0;
    end else if (count_en) begin
      if (freeze && (perf_dstall != '1)) perf_dstall <= perf_dstall + PERF_W'(1);
      if (fetch_stall && !load_use && (perf_istall != '1)) perf_istall <= perf_istall + PERF_W'(1);
      if (load_use && !freeze && (perf_luse != '1)) perf_luse <= perf_luse + PERF_W'(1);
    end
  end
`endif
endmodule
